// File: rtl/axi4_write_cmd_queue.sv
// rtl/axi4_write_cmd_queue.sv - write command FIFO and single-outstanding issue FSM for the AXI4 write master
//
// Purpose:
//   Buffers address/data write commands from a producer and hands them to the
//   AXI4 write master one at a time, in push order. Completions, dropped
//   commands (error or timeout) and the address of the last dropped command
//   are tracked.
//
// Ports:
//   CLOCK        sole clock, rising edge
//   RESET        asynchronous active-low reset
//   CMD_VALID    producer command valid
//   CMD_READY    queue can accept (not full, not in reset)
//   CMD_ADDR     command address
//   CMD_DATA     command data (one beat)
//   WRITE_START  one-cycle issue pulse to the master
//   WRITE_ADDR   registered address to the master
//   WRITE_DATA   registered data to the master
//   WRITE_READY  master able to accept a new command
//   WRITE_DONE   master completion pulse
//   WRITE_ERROR  qualifies WRITE_DONE, 1 = error response
//   LEVEL        FIFO occupancy
//   IDLE         FIFO empty and FSM idle
//   DONE_COUNT   successful writes, saturating
//   ERR_COUNT    dropped commands, saturating
//   ERR_ADDR     address of the most recent dropped command
//
// Build option:
//   WRITE_QUEUE_RETRY_EN - re-issue a command up to P_MAX_RETRY times after an
//   error response before dropping it. Timeouts are never retried.

module axi4_write_cmd_queue #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 256,
    parameter int P_DEPTH_LOG2 = 4,
    parameter int P_CNT_WIDTH  = 16,
    parameter int P_TIMEOUT    = 1024,
    parameter int P_MAX_RETRY  = 2
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [P_ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [P_DATA_WIDTH-1:0] CMD_DATA,
    output logic                    WRITE_START,
    output logic [P_ADDR_WIDTH-1:0] WRITE_ADDR,
    output logic [P_DATA_WIDTH-1:0] WRITE_DATA,
    input  logic                    WRITE_READY,
    input  logic                    WRITE_DONE,
    input  logic                    WRITE_ERROR,
    output logic [P_DEPTH_LOG2:0]   LEVEL,
    output logic                    IDLE,
    output logic [P_CNT_WIDTH-1:0]  DONE_COUNT,
    output logic [P_CNT_WIDTH-1:0]  ERR_COUNT,
    output logic [P_ADDR_WIDTH-1:0] ERR_ADDR
);

    localparam int DEPTH = 1 << P_DEPTH_LOG2;
    localparam int PW    = P_DEPTH_LOG2 + 1;
    localparam int TW    = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
    localparam int EW    = P_ADDR_WIDTH + P_DATA_WIDTH;

`ifdef WRITE_QUEUE_RETRY_EN
    localparam int RW = (P_MAX_RETRY > 0) ? $clog2(P_MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RETRY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [P_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [P_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [P_CNT_WIDTH-1:0]  done_cnt_q, done_cnt_d;
    logic [P_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [P_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
`ifdef WRITE_QUEUE_RETRY_EN
    logic [RW-1:0]           retry_q, retry_d;
`endif

    logic [EW-1:0]           mem_q [DEPTH];
    logic [EW-1:0]           head;
    logic [PW-1:0]           level;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic                    done_inc;

    // Extra pointer bit makes the difference equal to DEPTH when full.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == PW'(DEPTH));
    // Gated by RESET so the producer sees not-ready for the whole reset window.
    assign CMD_READY = RESET & ~full;
    assign push      = CMD_VALID & CMD_READY;
    assign head      = mem_q[rd_ptr_q[P_DEPTH_LOG2-1:0]];

    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem_q[wr_ptr_q[P_DEPTH_LOG2-1:0]] <= {CMD_ADDR, CMD_DATA};
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        timer_d    = timer_q;
        done_cnt_d = done_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
`ifdef WRITE_QUEUE_RETRY_EN
        retry_d    = retry_q;
`endif
        pop        = 1'b0;
        drop       = 1'b0;
        done_inc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((level != '0) && WRITE_READY) begin
                    {wr_addr_d, wr_data_d} = head;
                    pop     = 1'b1;
                    state_d = S_ISSUE;
`ifdef WRITE_QUEUE_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A completion in the final timeout cycle wins over the timeout.
                if (WRITE_DONE) begin
                    if (!WRITE_ERROR) begin
                        done_inc = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
`ifdef WRITE_QUEUE_RETRY_EN
                        if (retry_q < RW'(P_MAX_RETRY)) begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_RETRY;
                        end else begin
                            drop    = 1'b1;
                            state_d = S_IDLE;
                        end
`else
                        drop    = 1'b1;
                        state_d = S_IDLE;
`endif
                    end
                end else if (timer_q == TW'(P_TIMEOUT - 1)) begin
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef WRITE_QUEUE_RETRY_EN
            S_RETRY: begin
                // Address/data registers still hold the failed command.
                if (WRITE_READY) begin
                    state_d = S_ISSUE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done_inc && (done_cnt_q != '1)) begin
            done_cnt_d = done_cnt_q + 1'b1;
        end
        if (drop) begin
            err_addr_d = wr_addr_q;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end

        wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            timer_q    <= '0;
            done_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
`ifdef WRITE_QUEUE_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            timer_q    <= timer_d;
            done_cnt_q <= done_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
`ifdef WRITE_QUEUE_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign WRITE_START = (state_q == S_ISSUE);
    assign WRITE_ADDR  = wr_addr_q;
    assign WRITE_DATA  = wr_data_q;
    assign LEVEL       = level;
    assign IDLE        = (level == '0) && (state_q == S_IDLE);
    assign DONE_COUNT  = done_cnt_q;
    assign ERR_COUNT   = err_cnt_q;
    assign ERR_ADDR    = err_addr_q;

endmodule

// File: tb/tb_axi4_write_cmd_queue.sv
// tb/tb_axi4_write_cmd_queue.sv - self-checking bench for axi4_write_cmd_queue
module tb_axi4_write_cmd_queue;

    localparam int AW    = 32;
    localparam int DW    = 256;
    localparam int DL2   = 4;
    localparam int CW    = 16;
    localparam int TMO   = 1024;
    localparam int MR    = 2;
    localparam int DEPTH = 16;
`ifdef WRITE_QUEUE_RETRY_EN
    localparam int RETRIES = MR;
`else
    localparam int RETRIES = 0;
`endif

    logic          CLOCK       = 1'b0;
    logic          RESET       = 1'b0;
    logic          CMD_VALID   = 1'b0;
    logic          CMD_READY;
    logic [AW-1:0] CMD_ADDR    = '0;
    logic [DW-1:0] CMD_DATA    = '0;
    logic          WRITE_START;
    logic [AW-1:0] WRITE_ADDR;
    logic [DW-1:0] WRITE_DATA;
    logic          WRITE_READY = 1'b0;
    logic          WRITE_DONE  = 1'b0;
    logic          WRITE_ERROR = 1'b0;
    logic [DL2:0]  LEVEL;
    logic          IDLE;
    logic [CW-1:0] DONE_COUNT;
    logic [CW-1:0] ERR_COUNT;
    logic [AW-1:0] ERR_ADDR;

    axi4_write_cmd_queue #(
        .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_DEPTH_LOG2(DL2),
        .P_CNT_WIDTH(CW), .P_TIMEOUT(TMO), .P_MAX_RETRY(MR)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .WRITE_START(WRITE_START), .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA),
        .WRITE_READY(WRITE_READY), .WRITE_DONE(WRITE_DONE), .WRITE_ERROR(WRITE_ERROR),
        .LEVEL(LEVEL), .IDLE(IDLE),
        .DONE_COUNT(DONE_COUNT), .ERR_COUNT(ERR_COUNT), .ERR_ADDR(ERR_ADDR)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master model controls (written by the main sequence only).
    bit            ready_en   = 1'b1;
    bit            rand_ready = 1'b0;
    bit            rand_delay = 1'b0;
    logic [AW-1:0] err_addr   = 32'hFFFF_FFE0;
    logic [AW-1:0] hang_addr  = 32'hFFFF_FFC0;
    int            late_req   = 0;

    // Master model state (written by the master process only).
    int            late_ack   = 0;
    bit            m_pending  = 1'b0;
    int            m_cnt      = 0;
    logic [AW-1:0] m_addr     = '0;
    logic [AW-1:0] iss_addr_q [$];
    logic [DW-1:0] iss_data_q [$];
    int            iss_cyc_q  [$];

    initial begin
        forever begin
            @(negedge CLOCK);
            WRITE_DONE  = 1'b0;
            WRITE_ERROR = 1'b0;
            WRITE_READY = ready_en && (!rand_ready || ($urandom_range(0, 3) != 0));
            if (!RESET) begin
                m_pending = 1'b0;
            end else if (late_req != late_ack) begin
                late_ack   = late_req;
                WRITE_DONE = 1'b1;
            end else if (WRITE_START) begin
                iss_addr_q.push_back(WRITE_ADDR);
                iss_data_q.push_back(WRITE_DATA);
                iss_cyc_q.push_back(cyc);
                m_addr = WRITE_ADDR;
                if (WRITE_ADDR != hang_addr) begin
                    m_pending = 1'b1;
                    m_cnt     = rand_delay ? int'($urandom_range(1, 8)) : 5;
                end
            end else if (m_pending) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_pending   = 1'b0;
                    WRITE_DONE  = 1'b1;
                    WRITE_ERROR = (m_addr == err_addr);
                end
            end
        end
    end

    // Reference model: expected issue sequence and counters from push history.
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];
    int            chk_idx      = 0;
    int            exp_done     = 0;
    int            exp_err      = 0;
    logic [AW-1:0] exp_err_addr = '0;
    int            last_push_cyc = 0;

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit track);
        bit ok;
        int copies;
        ok        = 1'b0;
        CMD_VALID = 1'b1;
        CMD_ADDR  = a;
        CMD_DATA  = d;
        for (int t = 0; t < 3000 && !ok; t++) begin
            if (CMD_READY) begin
                ok            = 1'b1;
                last_push_cyc = cyc;
            end
            @(negedge CLOCK);
        end
        CMD_VALID = 1'b0;
        if (!ok) check_eq("push_accept", 0, 1);
        if (ok && track) begin
            copies = (a == err_addr) ? 1 + RETRIES : 1;
            for (int i = 0; i < copies; i++) begin
                exp_addr_q.push_back(a);
                exp_data_q.push_back(d);
            end
            if (a == err_addr || a == hang_addr) begin
                exp_err++;
                exp_err_addr = a;
            end else begin
                exp_done++;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && !IDLE; k++) @(negedge CLOCK);
        check_eq("idle_reached", IDLE, 1);
    endtask

    task automatic check_issued();
        check_eq("issue_count", iss_addr_q.size(), exp_addr_q.size());
        for (int i = chk_idx; i < exp_addr_q.size(); i++) begin
            if (i < iss_addr_q.size()) begin
                check_eq($sformatf("issue_addr[%0d]", i), iss_addr_q[i], exp_addr_q[i]);
                check_eq($sformatf("issue_data[%0d]", i), iss_data_q[i], exp_data_q[i]);
            end
        end
        chk_idx = exp_addr_q.size();
    endtask

    task automatic check_counts();
        check_eq("done_count", DONE_COUNT, exp_done);
        check_eq("err_count", ERR_COUNT, exp_err);
        check_eq("err_addr", ERR_ADDR, exp_err_addr);
    endtask

    initial begin
        int p0;
        logic [AW-1:0] a;

        // Reset window.
        repeat (32) @(negedge CLOCK);
        check_eq("rst_cmd_ready", CMD_READY, 0);
        check_eq("rst_level", LEVEL, 0);
        RESET = 1'b1;
        @(negedge CLOCK);
        check_eq("post_rst_cmd_ready", CMD_READY, 1);
        check_eq("post_rst_idle", IDLE, 1);
        check_eq("post_rst_start", WRITE_START, 0);
        check_eq("post_rst_waddr", WRITE_ADDR, 0);
        check_eq("post_rst_wdata", WRITE_DATA, 0);
        check_eq("post_rst_level", LEVEL, 0);
        check_counts();

        // Two back-to-back commands and issue latency.
        push(32'h00, 256'hF1, 1'b1);
        p0 = last_push_cyc;
        push(32'h20, 256'hF2, 1'b1);
        wait_idle(200);
        check_issued();
        if (iss_cyc_q.size() > 0) check_eq("issue_latency", iss_cyc_q[0] - p0, 2);
        check_counts();

        // Fill to full with the master stalled, then drain with wrap.
        ready_en = 1'b0;
        repeat (2) @(negedge CLOCK);
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i * 32), rnd_data(), 1'b1);
        check_eq("full_level", LEVEL, DEPTH);
        check_eq("full_cmd_ready", CMD_READY, 0);
        CMD_VALID = 1'b1;
        CMD_ADDR  = 32'h300;
        repeat (4) @(negedge CLOCK);
        check_eq("full_stall_level", LEVEL, DEPTH);
        ready_en = 1'b1;
        push(32'h300, rnd_data(), 1'b1);
        wait_idle(600);
        check_issued();
        check_counts();

        // Error response.
        err_addr = 32'h40;
        push(32'h40, rnd_data(), 1'b1);
        wait_idle(300);
        check_issued();
        check_counts();

        // Timeout, then the following command still issues.
        hang_addr = 32'h60;
        push(32'h60, rnd_data(), 1'b1);
        push(32'h80, rnd_data(), 1'b1);
        wait_idle(TMO + 300);
        check_issued();
        if (iss_cyc_q.size() >= 2)
            check_eq("timeout_gap", iss_cyc_q[iss_cyc_q.size()-1] - iss_cyc_q[iss_cyc_q.size()-2], TMO + 2);
        check_counts();

        // Randomized traffic with random master readiness and latency.
        rand_ready = 1'b1;
        rand_delay = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 5) == 0) ? 32'h40 : {17'd0, 10'($urandom_range(8, 1023)), 5'd0};
            push(a, rnd_data(), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge CLOCK);
        end
        wait_idle(3000);
        check_issued();
        check_counts();
        rand_ready = 1'b0;
        rand_delay = 1'b0;

        // Reset while waiting on a hung command with three queued behind it.
        push(32'h60, rnd_data(), 1'b1);
        for (int k = 0; k < 50 && iss_addr_q.size() < exp_addr_q.size(); k++) @(negedge CLOCK);
        check_issued();
        for (int i = 0; i < 3; i++) push(32'h500 + 32'(i * 32), rnd_data(), 1'b0);
        check_eq("pre_rst_level", LEVEL, 3);
        RESET = 1'b0;
        @(negedge CLOCK);
        check_eq("mid_rst_level", LEVEL, 0);
        check_eq("mid_rst_start", WRITE_START, 0);
        check_eq("mid_rst_cmd_ready", CMD_READY, 0);
        exp_done     = 0;
        exp_err      = 0;
        exp_err_addr = '0;
        check_counts();
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        late_req++;
        repeat (6) @(negedge CLOCK);
        check_eq("late_done_ignored", DONE_COUNT, 0);
        check_eq("post_mid_rst_idle", IDLE, 1);
        check_issued();
        push(32'hA0, rnd_data(), 1'b1);
        wait_idle(200);
        check_issued();
        check_counts();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
